gate_reduce_unit: RTL

//  Parametrised, registered successor to the 2-input OR gate: reduces NUM_IN operands of

---
 rtl/gate_pkg.sv | 50 +++++
 rtl/gate_skid_buf.sv | 79 +++++++
 rtl/gate_reduce_unit.sv | 106 ++++++++++
 3 files changed

// File: rtl/gate_pkg.sv
// gate_pkg: shared definitions for the gate reduction unit.
//   - Mode encodings carried on in_mode / out_mode.
//   - GATE_MAX_IN: widest operand column reduce_bits() can handle.
//   - decode_mode(): maps the reserved encoding onto OR.
//   - reduce_bits(): reduces one bit-column (the same bit of every operand)
//     under a given mode. Unused column positions are masked out so the
//     function is independent of the operand count.
package gate_pkg;

    localparam logic [2:0] GATE_OR   = 3'd0;
    localparam logic [2:0] GATE_AND  = 3'd1;
    localparam logic [2:0] GATE_XOR  = 3'd2;
    localparam logic [2:0] GATE_NOR  = 3'd3;
    localparam logic [2:0] GATE_NAND = 3'd4;
    localparam logic [2:0] GATE_XNOR = 3'd5;
    localparam logic [2:0] GATE_ACC  = 3'd6;
    localparam logic [2:0] GATE_RSVD = 3'd7;

    localparam int GATE_MAX_IN = 32;

    // Reserved encoding behaves as OR and is reported as OR.
    function automatic logic [2:0] decode_mode(input logic [2:0] mode);
        return (mode == GATE_RSVD) ? GATE_OR : mode;
    endfunction

    // bits: one column of operand bits, used: 1 for each populated position.
    // ACC mode reduces as OR; the accumulation itself lives in the top.
    function automatic logic reduce_bits(input logic [GATE_MAX_IN-1:0] bits,
                                         input logic [GATE_MAX_IN-1:0] used,
                                         input logic [2:0]             mode);
        logic r_or;
        logic r_and;
        logic r_xor;
        logic res;
        r_or  = |(bits & used);
        r_and = &(bits | ~used);
        r_xor = ^(bits & used);
        case (mode)
            GATE_OR:   res = r_or;
            GATE_AND:  res = r_and;
            GATE_XOR:  res = r_xor;
            GATE_NOR:  res = ~r_or;
            GATE_NAND: res = ~r_and;
            GATE_XNOR: res = ~r_xor;
            default:   res = r_or;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/gate_skid_buf.sv
// gate_skid_buf: 2-entry valid/ready result buffer.
//   Handshake: a word moves on in_valid & in_ready (push) and on
//   out_valid & out_ready (pop); out_data is stable while
//   out_valid & !out_ready, and out_valid only falls after a pop.
//   in_ready is a register (next-cycle "not full"), so a slot freed by a pop
//   is only offered to the producer from the following cycle.
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   in_valid/in_ready   producer side handshake
//   in_data  [DW-1:0]   word to store
//   out_valid/out_ready consumer side handshake
//   out_data [DW-1:0]   oldest stored word
module gate_skid_buf #(
    parameter int DW = 11
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data
);

    logic [DW-1:0] slot0;   // head (oldest)
    logic [DW-1:0] slot1;   // second entry
    logic [1:0]    count;
    logic [1:0]    count_next;
    logic          ready_q;
    logic          push;
    logic          pop;

    assign push      = in_valid & ready_q;
    assign pop       = (count != 2'd0) & out_ready;
    assign in_ready  = ready_q;
    assign out_valid = (count != 2'd0);
    assign out_data  = slot0;

    always_comb begin
        count_next = count;
        case ({push, pop})
            2'b10:   count_next = count + 2'd1;
            2'b01:   count_next = count - 2'd1;
            default: count_next = count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count   <= 2'd0;
            slot0   <= '0;
            slot1   <= '0;
            ready_q <= 1'b1;
        end else begin
            count   <= count_next;
            ready_q <= (count_next != 2'd2);
            // A push never meets a full buffer (ready_q is low then), and a
            // pop never meets an empty one.
            case ({push, pop})
                2'b10: begin
                    if (count == 2'd0) slot0 <= in_data;
                    else               slot1 <= in_data;
                end
                2'b01: slot0 <= slot1;
                2'b11: begin
                    if (count == 2'd1) begin
                        slot0 <= in_data;
                    end else begin
                        slot0 <= slot1;
                        slot1 <= in_data;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/gate_reduce_unit.sv
// gate_reduce_unit: registered NUM_IN-operand bitwise reduction.
//   Each accepted beat is reduced column-wise under in_mode
//   (OR/AND/XOR/NOR/NAND/XNOR, 7 treated as OR) and the result is queued
//   with 1-cycle latency. ACC mode ORs beats into a sticky accumulator and
//   only emits on in_last, then clears it. acc_clr zeroes the accumulator
//   before any coincident ACC beat is folded in.
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   in_valid/in_ready     operand handshake (in_ready is registered)
//   in_data [NUM_IN*WIDTH] operands, operand k at [k*WIDTH +: WIDTH]
//   in_mode [3]           function for this beat
//   in_last               closes an ACC accumulation
//   acc_clr               clears the accumulator
//   out_valid/out_ready   result handshake
//   out_data [WIDTH]      result
//   out_mode [3]          mode that produced out_data
module gate_reduce_unit
    import gate_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int NUM_IN = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [2:0]              in_mode,
    input  logic                    in_last,
    input  logic                    acc_clr,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic [2:0]              out_mode
);

    localparam int DW = WIDTH + 3;

    logic [2:0]             eff_mode;
    logic                   is_acc;
    logic                   accept;
    logic                   emit;
    logic [GATE_MAX_IN-1:0] used_mask;
    logic [GATE_MAX_IN-1:0] col;
    logic [WIDTH-1:0]       red;
    logic [WIDTH-1:0]       acc;
    logic [WIDTH-1:0]       acc_base;
    logic [WIDTH-1:0]       acc_sum;
    logic [DW-1:0]          push_data;
    logic [DW-1:0]          head_data;
    logic                   buf_valid;

    assign eff_mode = decode_mode(in_mode);
    assign is_acc   = (eff_mode == GATE_ACC);
    assign accept   = in_valid & in_ready;
    // ACC beats without in_last are consumed silently.
    assign emit     = ~is_acc | in_last;

    always_comb begin
        used_mask = '0;
        for (int k = 0; k < NUM_IN; k++) used_mask[k] = 1'b1;
    end

    always_comb begin
        red = '0;
        col = '0;
        for (int b = 0; b < WIDTH; b++) begin
            col = '0;
            for (int k = 0; k < NUM_IN; k++) col[k] = in_data[k*WIDTH + b];
            red[b] = reduce_bits(col, used_mask, eff_mode);
        end
    end

    // Clear takes effect before the coincident beat is accumulated.
    assign acc_base  = acc_clr ? '0 : acc;
    assign acc_sum   = acc_base | red;
    assign push_data = {eff_mode, (is_acc ? acc_sum : red)};
    assign buf_valid = in_valid & emit;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (accept && is_acc) begin
            acc <= in_last ? '0 : acc_sum;
        end else if (acc_clr) begin
            acc <= '0;
        end
    end

    // Buffer readiness gates every beat, including silent ACC beats, so the
    // accumulator never races a full buffer.
    gate_skid_buf #(.DW(DW)) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (buf_valid),
        .in_ready  (in_ready),
        .in_data   (push_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (head_data)
    );

    assign out_mode = head_data[DW-1 -: 3];
    assign out_data = head_data[WIDTH-1:0];

endmodule
